universal_shift_register: RTL and testbench

//   Parametrised successor to the 8-bit walking-bit shift register used in the state-machine labs.
//   - Adds parallel load, serial in/out and five shift/rotate modes.
//   - Adds a counted multi-step operation with busy/done handshake.
//   - Feeds LED walkers, serial converters and sequence generators in lab top levels.

---
 rtl/universal_shift_register.sv | 125 ++++++++++++
 tb/tb_universal_shift_register.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus a counted multi-step shift/rotate
// operation with a busy/done handshake. Steps are applied one per clock while busy.
module universal_shift_register #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [2:0] ModeShl  = 3'b000;
  localparam logic [2:0] ModeShr  = 3'b001;
  localparam logic [2:0] ModeRotl = 3'b010;
  localparam logic [2:0] ModeRotr = 3'b011;
  localparam logic [2:0] ModeAsr  = 3'b100;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;

  // Next-state logic: IDLE accepts load/start, SHIFT applies one step per edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    sout_d  = sout_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          q_d = D0;
        end else if (start) begin
          if (amount == '0) begin
            state_d = StDone;
          end else begin
            mode_d  = mode;
            cnt_d   = amount;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        // Reserved modes still consume a step but leave Q and sout untouched.
        case (mode_q)
          ModeShl: begin
            q_d    = {q_q[WIDTH-2:0], sin};
            sout_d = q_q[WIDTH-1];
          end
          ModeShr: begin
            q_d    = {sin, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          ModeRotl: begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
          end
          ModeRotr: begin
            q_d    = {q_q[0], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          ModeAsr: begin
            q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          default: begin
            q_d    = q_q;
            sout_d = sout_q;
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      q_q     <= RST_VAL;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
    end
  end

  assign Q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8, CNT_W=4, RST_VAL=8'h01).
// Expected values come from an arithmetic reference model of each step kind.
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic [7:0] D0;
  logic       load;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amount;
  logic       sin;
  logic [7:0] Q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int exp_q    = 1;
  int exp_sout = 0;

  universal_shift_register #(
    .WIDTH  (8),
    .CNT_W  (4),
    .RST_VAL(8'h01)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .D0    (D0),
    .load  (load),
    .start (start),
    .mode  (mode),
    .amount(amount),
    .sin   (sin),
    .Q     (Q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eb, input int ed);
    chk({tag, ".Q"}, 32'(Q), 32'(exp_q));
    chk({tag, ".sout"}, 32'(sout), 32'(exp_sout));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step of the named operation, in plain 8-bit arithmetic.
  task automatic model_step(input int m, input int s);
    int q;
    q = exp_q;
    case (m)
      0: begin exp_sout = q / 128; exp_q = (q * 2) % 256 + s;         end
      1: begin exp_sout = q % 2;   exp_q = q / 2 + s * 128;           end
      2: begin exp_sout = q / 128; exp_q = (q * 2) % 256 + q / 128;   end
      3: begin exp_sout = q % 2;   exp_q = q / 2 + (q % 2) * 128;     end
      4: begin exp_sout = q % 2;   exp_q = q / 2 + (q / 128) * 128;   end
      default: ;
    endcase
  endtask

  task automatic do_load(input int d);
    D0   = 8'(d);
    load = 1'b1;
    tick();
    load  = 1'b0;
    exp_q = d;
    chk_all("load", 0, 0);
  endtask

  // Counted operation. sin_sel<0 drives random sin; noisy=1 toggles load/start/mode
  // while the operation runs, which must have no effect.
  task automatic run_op(input string tag, input int m, input int amt, input int sin_sel,
                        input int noisy);
    int s;
    mode   = 3'(m);
    amount = 4'(amt);
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < amt; i++) begin
      chk_all({tag, ".busy"}, 1, 0);
      s   = (sin_sel < 0) ? int'($urandom_range(1, 0)) : sin_sel;
      sin = 1'(s);
      if (noisy != 0) begin
        load   = 1'b1;
        start  = 1'b1;
        D0     = 8'($urandom);
        mode   = 3'($urandom);
        amount = 4'($urandom);
      end
      tick();
      model_step(m, s);
    end
    chk_all({tag, ".done"}, 0, 1);
    tick();
    load  = 1'b0;
    start = 1'b0;
    chk_all({tag, ".idle"}, 0, 0);
  endtask

  initial begin
    rst    = 1'b1;
    D0     = 8'hFF;
    load   = 1'b1;
    start  = 1'b1;
    mode   = 3'd0;
    amount = 4'd5;
    sin    = 1'b1;

    // T1: reset held for 3 cycles overrides load/start
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 0, 0);
    end
    rst   = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    sin   = 1'b0;

    // Load has priority over start
    D0     = 8'h3C;
    load   = 1'b1;
    start  = 1'b1;
    amount = 4'd2;
    tick();
    load  = 1'b0;
    start = 1'b0;
    exp_q = 8'h3C;
    chk_all("load_prio", 0, 0);
    tick();
    chk_all("load_prio_hold", 0, 0);

    // T2: load A5, ROTL by 3
    do_load(8'hA5);
    run_op("t2_rotl", 2, 3, -1, 0);
    chk("t2_q_const", 32'(Q), 32'h2D);
    chk("t2_sout_const", 32'(sout), 32'h1);

    // T3: shifts from 80
    do_load(8'h80);
    run_op("t3_asr", 4, 3, -1, 0);
    chk("t3_asr_const", 32'(Q), 32'hF0);
    do_load(8'h80);
    run_op("t3_shr", 1, 3, 0, 0);
    chk("t3_shr_const", 32'(Q), 32'h10);
    do_load(8'h80);
    run_op("t3_shl", 0, 3, 1, 0);
    chk("t3_shl_const", 32'(Q), 32'h07);
    chk("t3_shl_sout", 32'(sout), 32'h0);

    // T4: zero count and overflowing rotates
    run_op("t4_zero", 2, 0, -1, 0);
    do_load(8'h01);
    run_op("t4_rot8", 2, 8, -1, 0);
    chk("t4_rot8_const", 32'(Q), 32'h01);
    run_op("t4_rot9", 2, 9, -1, 0);
    chk("t4_rot9_const", 32'(Q), 32'h03 - 32'h01);
    do_load(8'h96);
    run_op("t4_shr15", 1, 15, 1, 0);
    chk("t4_shr15_const", 32'(Q), 32'hFF);
    do_load(8'h96);
    run_op("t4_asr12", 4, 12, -1, 0);
    chk("t4_asr12_const", 32'(Q), 32'hFF);

    // Reserved mode: counted timing, Q and sout hold
    do_load(8'h5A);
    run_op("rsvd", 6, 4, -1, 0);
    chk("rsvd_const", 32'(Q), 32'h5A);

    // T5: load/start/mode/amount wiggled during SHIFT and DONE
    do_load(8'hC3);
    run_op("t5_noisy", 3, 5, -1, 1);

    // T6: reset during step 2 of a 5-step ROTL
    do_load(8'h11);
    mode   = 3'd2;
    amount = 4'd5;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    model_step(2, 0);
    chk_all("t6_step1", 1, 0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    exp_q    = 8'h01;
    exp_sout = 0;
    chk_all("t6_reset", 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("t6_no_done", 0, 0);
    end
    run_op("t6_fresh", 2, 5, -1, 0);
    chk("t6_fresh_const", 32'(Q), 32'h20);

    // Randomized operations against the model
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(3, 0) == 0) do_load(int'($urandom_range(255, 0)));
      run_op("rand", int'($urandom_range(7, 0)), int'($urandom_range(15, 0)), -1,
             int'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
